ram_readback_checker: RTL and testbench

- Downstream consumer of the 32x8 single-port RAM test stage.
- Taps the RAM read strobe, read address and read data, and aligns each read with its data using a latency pipeline.
- Compares each read word against the deterministic write pattern and reports pass/fail, error count and first failing address per check pass.
- Sits between the RAM harness and status LEDs / SignalTap probes.

---
 rtl/ram_test_pkg.sv | 20 ++
 rtl/rd_align_pipe.sv | 36 +++
 rtl/ram_readback_checker.sv | 142 ++++++++++++++
 tb/tb_ram_readback_checker.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_test_pkg.sv
// Shared types and constants for the 32x8 RAM test stage and its readback checker.
package ram_test_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    DONE
  } chk_state_e;

  localparam int RAM_AW      = 5;
  localparam int RAM_DW      = 8;
  localparam int RAM_DEPTH   = 32;
  localparam int ERR_CNT_MAX = 255;

  // Deterministic write pattern; the caller truncates the result to its data width.
  function automatic logic [31:0] exp_word(input logic [31:0] addr, input logic [31:0] offset);
    return addr + offset;
  endfunction

endpackage

// File: rtl/rd_align_pipe.sv
// Delays {rden, address} by RD_LATENCY clocks so each read lines up with its returned data.
module rd_align_pipe #(
  parameter int AW         = 5,
  parameter int RD_LATENCY = 1
) (
  input  logic          clk_50M,
  input  logic          RST_N,
  input  logic          flush_i,
  input  logic          vld_i,
  input  logic [AW-1:0] addr_i,
  output logic          vld_o,
  output logic [AW-1:0] addr_o
);

  logic [RD_LATENCY-1:0]         vld_q;
  logic [RD_LATENCY-1:0][AW-1:0] addr_q;

  // Flush kills every in-flight valid, including the read being sampled this cycle.
  always_ff @(posedge clk_50M or negedge RST_N) begin
    if (!RST_N) begin
      vld_q  <= '0;
      addr_q <= '0;
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        vld_q[i]  <= vld_q[i-1] & ~flush_i;
        addr_q[i] <= addr_q[i-1];
      end
      vld_q[0]  <= vld_i & ~flush_i;
      addr_q[0] <= addr_i;
    end
  end

  assign vld_o  = vld_q[RD_LATENCY-1];
  assign addr_o = addr_q[RD_LATENCY-1];

endmodule

// File: rtl/ram_readback_checker.sv
// Checks RAM read data against the address+offset pattern and reports per-pass results.
// Optional: define RAM_CHK_STOP_ON_ERR_EN to end a pass at its first mismatch.
module ram_readback_checker
  import ram_test_pkg::*;
#(
  parameter int             AW          = RAM_AW,
  parameter int             DW          = RAM_DW,
  parameter int             DEPTH       = RAM_DEPTH,
  parameter int             RD_LATENCY  = 1,
  parameter logic [DW-1:0]  DATA_OFFSET = '0
) (
  input  logic          clk_50M,
  input  logic          RST_N,
  input  logic          start,
  input  logic          rden,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] rddata,
  output logic          chk_busy,
  output logic          chk_done,
  output logic          pass,
  output logic [7:0]    err_cnt,
  output logic [AW:0]   words_checked,
  output logic          first_err_valid,
  output logic [AW-1:0] first_err_addr
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [7:0]  ERR_MAX = 8'(ERR_CNT_MAX);

  chk_state_e    state_q, state_d;
  logic [7:0]    err_q, err_d;
  logic [AW:0]   wc_q, wc_d;
  logic          fev_q, fev_d;
  logic [AW-1:0] fea_q, fea_d;
  logic          pass_q, pass_d;
  logic          flush;
  logic          cmpVld;
  logic [AW-1:0] cmpAddr;
  logic [DW-1:0] expWord;
  logic          mismatch;
  logic          endOfPass;

  rd_align_pipe #(
    .AW         (AW),
    .RD_LATENCY (RD_LATENCY)
  ) u_pipe (
    .clk_50M (clk_50M),
    .RST_N   (RST_N),
    .flush_i (flush),
    .vld_i   (rden),
    .addr_i  (address),
    .vld_o   (cmpVld),
    .addr_o  (cmpAddr)
  );

  assign expWord  = DW'(exp_word(32'(cmpAddr), 32'(DATA_OFFSET)));
  assign mismatch = cmpVld && (rddata != expWord);

  always_ff @(posedge clk_50M or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      err_q   <= '0;
      wc_q    <= '0;
      fev_q   <= 1'b0;
      fea_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      wc_q    <= wc_d;
      fev_q   <= fev_d;
      fea_q   <= fea_d;
      pass_q  <= pass_d;
    end
  end

  // pass is latched on entry to DONE so it is already valid during the chk_done pulse.
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    wc_d      = wc_q;
    fev_d     = fev_q;
    fea_d     = fea_q;
    pass_d    = pass_q;
    flush     = 1'b0;
    endOfPass = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          err_d   = '0;
          wc_d    = '0;
          fev_d   = 1'b0;
          fea_d   = '0;
          flush   = 1'b1;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (start) begin
          err_d = '0;
          wc_d  = '0;
          fev_d = 1'b0;
          fea_d = '0;
          flush = 1'b1;
        end else if (cmpVld) begin
          wc_d = wc_q + (AW+1)'(1);
          if (mismatch) begin
            if (err_q != ERR_MAX) err_d = err_q + 8'd1;
            if (!fev_q) begin
              fev_d = 1'b1;
              fea_d = cmpAddr;
            end
          end
`ifdef RAM_CHK_STOP_ON_ERR_EN
          endOfPass = (wc_d == DEPTH_W) || mismatch;
`else
          endOfPass = (wc_d == DEPTH_W);
`endif
          if (endOfPass) begin
            state_d = DONE;
            pass_d  = (err_d == '0);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign chk_busy        = (state_q == ARMED);
  assign chk_done        = (state_q == DONE);
  assign pass            = pass_q;
  assign err_cnt         = err_q;
  assign words_checked   = wc_q;
  assign first_err_valid = fev_q;
  assign first_err_addr  = fea_q;

endmodule

// File: tb/tb_ram_readback_checker.sv
// Directed bench for ram_readback_checker: table of full passes plus restart, reset and saturation sequences.
module tb_ram_readback_checker;

  logic       clk_50M = 1'b0;
  logic       RST_N   = 1'b0;
  logic       start   = 1'b0;
  logic       rden    = 1'b0;
  logic [4:0] address = '0;
  logic       invert  = 1'b0;
  logic [7:0] mem [32];
  logic [7:0] q1 = '0;
  logic [7:0] q2 = '0;
  logic [7:0] dataLat1, dataLat2;

  int errors   = 0;
  int checks   = 0;
  int doneCntA = 0;

  logic       busyA, doneA, passA, fevA;
  logic [7:0] errA;
  logic [5:0] wcA;
  logic [4:0] feaA;
  logic       busyB, doneB, passB, fevB;
  logic [7:0] errB;
  logic [5:0] wcB;
  logic [4:0] feaB;
  logic       busyC, doneC, passC, fevC;
  logic [7:0] errC;
  logic [9:0] wcC;
  logic [8:0] feaC;
  logic       busyD, doneD, passD, fevD;
  logic [7:0] errD;
  logic [5:0] wcD;
  logic [4:0] feaD;

  always #10 clk_50M = ~clk_50M;

  // Behavioural RAM read port: q1 is the one-clock data, q2 a second register stage.
  always @(posedge clk_50M) begin
    if (rden) q1 <= mem[address];
    q2 <= q1;
  end

  assign dataLat1 = q1 ^ {8{invert}};
  assign dataLat2 = q2 ^ {8{invert}};

  always @(negedge clk_50M) if (doneA) doneCntA++;

  ram_readback_checker u_dutA (
    .clk_50M(clk_50M), .RST_N(RST_N), .start(start), .rden(rden), .address(address),
    .rddata(dataLat1), .chk_busy(busyA), .chk_done(doneA), .pass(passA), .err_cnt(errA),
    .words_checked(wcA), .first_err_valid(fevA), .first_err_addr(feaA));

  ram_readback_checker #(.RD_LATENCY(2), .DATA_OFFSET(8'h10)) u_dutB (
    .clk_50M(clk_50M), .RST_N(RST_N), .start(start), .rden(rden), .address(address),
    .rddata(dataLat2), .chk_busy(busyB), .chk_done(doneB), .pass(passB), .err_cnt(errB),
    .words_checked(wcB), .first_err_valid(fevB), .first_err_addr(feaB));

  ram_readback_checker #(.AW(9), .DEPTH(300)) u_dutC (
    .clk_50M(clk_50M), .RST_N(RST_N), .start(start), .rden(rden), .address({4'b0, address}),
    .rddata(dataLat1), .chk_busy(busyC), .chk_done(doneC), .pass(passC), .err_cnt(errC),
    .words_checked(wcC), .first_err_valid(fevC), .first_err_addr(feaC));

  ram_readback_checker #(.RD_LATENCY(1), .DATA_OFFSET(8'h10)) u_dutD (
    .clk_50M(clk_50M), .RST_N(RST_N), .start(start), .rden(rden), .address(address),
    .rddata(q2), .chk_busy(busyD), .chk_done(doneD), .pass(passD), .err_cnt(errD),
    .words_checked(wcD), .first_err_valid(fevD), .first_err_addr(feaD));

  typedef struct {
    int         badAddr0;
    logic [7:0] badVal0;
    int         badAddr1;
    logic [7:0] badVal1;
    bit         inv;
    bit         gap;
    bit         expPass;
    int         expErr;
    int         expWc;
    bit         expFev;
    int         expFea;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic loadMem(input logic [7:0] offset);
    for (int i = 0; i < 32; i++) mem[i] = 8'(i) + offset;
  endtask

  task automatic pulseStart();
    @(negedge clk_50M);
    start = 1'b1;
    @(negedge clk_50M);
    start = 1'b0;
  endtask

  task automatic applyStimulus(input int nReads, input bit gap);
    for (int i = 0; i < nReads; i++) begin
      rden    = 1'b1;
      address = 5'(i % 32);
      @(negedge clk_50M);
      if (gap) begin
        rden = 1'b0;
        @(negedge clk_50M);
      end
    end
    rden = 1'b0;
  endtask

  task automatic waitDoneA(input int base);
    for (int k = 0; k < 20 && doneCntA == base; k++) @(negedge clk_50M);
    repeat (3) @(negedge clk_50M);
    checkOutput("doneA single pulse", 32'(doneCntA - base), 32'd1);
  endtask

  function automatic logic [31:0] allOutA();
    return 32'({busyA, doneA, passA, errA, wcA, fevA, feaA});
  endfunction

  initial begin
    int base;

    vecs[0] = '{-1, 8'h00, -1, 8'h00, 0, 0, 1, 0, 32, 0, 0};
`ifdef RAM_CHK_STOP_ON_ERR_EN
    vecs[1] = '{5, 8'hFF, 20, 8'h00, 0, 0, 0, 1, 6, 1, 5};
    vecs[2] = '{-1, 8'h00, -1, 8'h00, 1, 0, 0, 1, 1, 1, 0};
`else
    vecs[1] = '{5, 8'hFF, 20, 8'h00, 0, 0, 0, 2, 32, 1, 5};
    vecs[2] = '{-1, 8'h00, -1, 8'h00, 1, 0, 0, 32, 32, 1, 0};
`endif
    vecs[3] = '{31, 8'h00, -1, 8'h00, 0, 1, 0, 1, 32, 1, 31};
    vecs[4] = '{-1, 8'h00, -1, 8'h00, 0, 1, 1, 0, 32, 0, 0};

    loadMem(8'h00);
    repeat (3) @(negedge clk_50M);
    checkOutput("outputs in reset", allOutA(), 32'd0);
    RST_N = 1'b1;
    repeat (2) @(negedge clk_50M);
    checkOutput("outputs after reset", allOutA(), 32'd0);

    // Latency-2 checker on gapped reads, and a latency-1 checker mis-set on the same data.
    loadMem(8'h10);
    pulseStart();
    applyStimulus(32, 1'b1);
    repeat (12) @(negedge clk_50M);
    checkOutput("B lat2 pass", 32'(passB), 32'd1);
    checkOutput("B lat2 words", 32'(wcB), 32'd32);
    checkOutput("B lat2 err_cnt", 32'(errB), 32'd0);
    checkOutput("D mis-set latency pass", 32'(passD), 32'd0);
    checkOutput("D mis-set first_err_addr", 32'(feaD), 32'd0);

    for (int v = 0; v < 5; v++) begin
      loadMem(8'h00);
      if (vecs[v].badAddr0 >= 0) mem[vecs[v].badAddr0] = vecs[v].badVal0;
      if (vecs[v].badAddr1 >= 0) mem[vecs[v].badAddr1] = vecs[v].badVal1;
      invert = vecs[v].inv;
      base = doneCntA;
      pulseStart();
      checkOutput($sformatf("vec%0d busy after start", v), 32'(busyA), 32'd1);
      applyStimulus(32, vecs[v].gap);
      waitDoneA(base);
      checkOutput($sformatf("vec%0d pass", v), 32'(passA), 32'(vecs[v].expPass));
      checkOutput($sformatf("vec%0d err_cnt", v), 32'(errA), 32'(vecs[v].expErr));
      checkOutput($sformatf("vec%0d words_checked", v), 32'(wcA), 32'(vecs[v].expWc));
      checkOutput($sformatf("vec%0d first_err_valid", v), 32'(fevA), 32'(vecs[v].expFev));
      checkOutput($sformatf("vec%0d first_err_addr", v), 32'(feaA), 32'(vecs[v].expFea));
    end
    invert = 1'b0;

    // Restart mid-pass, then abort with reset; pass=1 from the last vector must survive start.
    loadMem(8'h00);
    base = doneCntA;
    pulseStart();
    checkOutput("pass held across start", 32'(passA), 32'd1);
    applyStimulus(10, 1'b0);
    @(negedge clk_50M);
    checkOutput("words before restart", 32'(wcA), 32'd10);
    pulseStart();
    checkOutput("words after restart", 32'(wcA), 32'd0);
    checkOutput("busy after restart", 32'(busyA), 32'd1);
    applyStimulus(4, 1'b0);
    @(negedge clk_50M);
    checkOutput("words after 4 more", 32'(wcA), 32'd4);
    RST_N = 1'b0;
    #1;
    checkOutput("outputs on mid-pass reset", allOutA(), 32'd0);
    repeat (3) @(negedge clk_50M);
    RST_N = 1'b1;
    repeat (5) @(negedge clk_50M);
    checkOutput("outputs after abort", allOutA(), 32'd0);
    checkOutput("no done on abort", 32'(doneCntA - base), 32'd0);

    // 300 always-wrong reads: the 300-deep checker saturates, the 32-deep one ignores reads after DONE.
    invert = 1'b1;
    pulseStart();
    applyStimulus(300, 1'b0);
    repeat (10) @(negedge clk_50M);
`ifdef RAM_CHK_STOP_ON_ERR_EN
    checkOutput("C err_cnt stop", 32'(errC), 32'd1);
    checkOutput("C words stop", 32'(wcC), 32'd1);
    checkOutput("A err_cnt stop", 32'(errA), 32'd1);
`else
    checkOutput("C err_cnt saturated", 32'(errC), 32'd255);
    checkOutput("C words_checked", 32'(wcC), 32'd300);
    checkOutput("A err_cnt after 300 reads", 32'(errA), 32'd32);
    checkOutput("A words after 300 reads", 32'(wcA), 32'd32);
`endif
    checkOutput("C pass", 32'(passC), 32'd0);
    checkOutput("C first_err_addr", 32'(feaC), 32'd0);
    checkOutput("A busy idle", 32'(busyA), 32'd0);
    invert = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
